register_file_mp: RTL and testbench

Parametrised multi-port RV32I/RV32E integer register file with an integrated write scoreboard.
- Serves NUM_RD_PORTS combinational reads and NUM_WR_PORTS synchronous writebacks per cycle.
- Tracks per-register pending-write (busy) bits, which issue sets and writeback clears.
- Sits between decode/issue (read + mark destination) and the writeback stage of a multi-issue pipeline.

---
 rtl/register_file_mp_if.sv | 32 +++
 rtl/register_file_mp.sv | 112 +++++++++++
 tb/tb_register_file_mp.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/register_file_mp_if.sv
// Bus bundle between the issue/writeback pipeline (master) and the register file (slave).
// Read, writeback and issue/scoreboard signals; clock and reset stay outside.
interface register_file_mp_if #(
  parameter int unsigned REG_DATA_W   = 32,
  parameter int unsigned REG_NUMBER   = 32,
  parameter int unsigned ADDR_WIDTH   = $clog2(REG_NUMBER),
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned NUM_WR_PORTS = 1
);

  logic [NUM_WR_PORTS-1:0]            wr_en;
  logic [NUM_WR_PORTS*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WR_PORTS*REG_DATA_W-1:0] wr_data;
  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD_PORTS*REG_DATA_W-1:0] rd_data;
  logic [NUM_RD_PORTS-1:0]            rd_busy;
  logic                               iss_en;
  logic [ADDR_WIDTH-1:0]              iss_addr;
  logic                               iss_ready;
  logic [REG_NUMBER-1:0]              busy_vec;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
    input  rd_data, rd_busy, iss_ready, busy_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
    output rd_data, rd_busy, iss_ready, busy_vec
  );

endinterface

// File: rtl/register_file_mp.sv
// Multi-port RV32I/RV32E integer register file with a per-register pending-write scoreboard.
// Optional macro RF_BYPASS_EN: same-cycle write-through forwarding to the read ports.
module register_file_mp #(
  parameter int unsigned REG_DATA_W   = 32,
  parameter int unsigned REG_NUMBER   = 32,
  parameter int unsigned ADDR_WIDTH   = $clog2(REG_NUMBER),
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned NUM_WR_PORTS = 1
) (
  input  logic              rf_clk,
  input  logic              rf_ares,
  register_file_mp_if.slave rf_bus
);

  logic [REG_DATA_W-1:0] regs_q [REG_NUMBER];
  logic [REG_DATA_W-1:0] regs_d [REG_NUMBER];
  logic [REG_NUMBER-1:0] busy_q;
  logic [REG_NUMBER-1:0] busy_d;

  logic [ADDR_WIDTH-1:0] wr_addr_a [NUM_WR_PORTS];
  logic [REG_DATA_W-1:0] wr_data_a [NUM_WR_PORTS];
  logic [ADDR_WIDTH-1:0] rd_addr_a [NUM_RD_PORTS];
  logic [REG_DATA_W-1:0] rd_data_c [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0] rd_busy_c;

  logic iss_hit_wr_c;
  logic iss_ready_c;
  logic iss_accept_c;

  // Unpack the flat port buses into per-port arrays
  for (genvar k = 0; k < NUM_WR_PORTS; k++) begin : g_wr_unpack
    assign wr_addr_a[k] = rf_bus.wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data_a[k] = rf_bus.wr_data[k*REG_DATA_W +: REG_DATA_W];
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_pack
    assign rd_addr_a[p] = rf_bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign rf_bus.rd_data[p*REG_DATA_W +: REG_DATA_W] = rd_data_c[p];
  end

  // A writeback retiring the destination this cycle removes the WAW hazard
  always_comb begin
    iss_hit_wr_c = 1'b0;
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      if (rf_bus.wr_en[k] && (wr_addr_a[k] == rf_bus.iss_addr)) begin
        iss_hit_wr_c = 1'b1;
      end
    end
  end

  always_comb begin
    iss_ready_c  = !busy_q[rf_bus.iss_addr] || iss_hit_wr_c ||
                   (rf_bus.iss_addr == ADDR_WIDTH'(0));
    iss_accept_c = rf_bus.iss_en && iss_ready_c && (rf_bus.iss_addr != ADDR_WIDTH'(0));
  end

  // Next state: later ports override earlier ones, issue set overrides writeback clear
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      if (rf_bus.wr_en[k]) begin
        regs_d[wr_addr_a[k]] = wr_data_a[k];
        busy_d[wr_addr_a[k]] = 1'b0;
      end
    end
    if (iss_accept_c) begin
      busy_d[rf_bus.iss_addr] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge rf_clk or posedge rf_ares) begin
    if (rf_ares) begin
      for (int i = 0; i < REG_NUMBER; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports: zero-latency array access with optional write-through
  always_comb begin
    rd_busy_c = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_data_c[p] = regs_q[rd_addr_a[p]];
      rd_busy_c[p] = busy_q[rd_addr_a[p]];
`ifdef RF_BYPASS_EN
      for (int k = 0; k < NUM_WR_PORTS; k++) begin
        if (!rf_ares && rf_bus.wr_en[k] && (wr_addr_a[k] == rd_addr_a[p]) &&
            (rd_addr_a[p] != ADDR_WIDTH'(0))) begin
          rd_data_c[p] = wr_data_a[k];
          rd_busy_c[p] = 1'b0;
        end
      end
`endif
      if (rd_addr_a[p] == ADDR_WIDTH'(0)) begin
        rd_data_c[p] = '0;
        rd_busy_c[p] = 1'b0;
      end
    end
  end

  assign rf_bus.rd_busy   = rd_busy_c;
  assign rf_bus.iss_ready = iss_ready_c;
  assign rf_bus.busy_vec  = busy_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: 2 read ports, 2 write ports, RV32I sizing.
// Expectations for same-cycle reads of a written register follow RF_BYPASS_EN.
module tb_register_file_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned AW = 5;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [1:0]  wr_en;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic        e_rb0;
    logic        e_rb1;
    logic        e_rdy;
    logic [31:0] e_bv;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs [14];

  register_file_mp_if #(
    .REG_DATA_W(DW), .REG_NUMBER(NR), .ADDR_WIDTH(AW),
    .NUM_RD_PORTS(2), .NUM_WR_PORTS(2)
  ) bus ();

  register_file_mp #(
    .REG_DATA_W(DW), .REG_NUMBER(NR), .ADDR_WIDTH(AW),
    .NUM_RD_PORTS(2), .NUM_WR_PORTS(2)
  ) dut (
    .rf_clk (clk),
    .rf_ares(rst),
    .rf_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
    input logic [4:0] wa1, input logic [31:0] wd1,
    input logic [4:0] ra0, input logic [4:0] ra1,
    input logic ie, input logic [4:0] ia,
    input logic [31:0] e0, input logic [31:0] e1,
    input logic b0, input logic b1, input logic rdy, input logic [31:0] bv);
    vec_t v;
    v.wr_en = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.iss_en = ie; v.iss_addr = ia;
    v.e_rd0 = e0; v.e_rd1 = e1; v.e_rb0 = b0; v.e_rb1 = b1; v.e_rdy = rdy; v.e_bv = bv;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.wr_en    = v.wr_en;
    bus.wr_addr  = {v.wa1, v.wa0};
    bus.wr_data  = {v.wd1, v.wd0};
    bus.rd_addr  = {v.ra1, v.ra0};
    bus.iss_en   = v.iss_en;
    bus.iss_addr = v.iss_addr;
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_addr  = {ra1, ra0};
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle(5'd0, 5'd0);

    vecs[0]  = mk(2'b11, 5'd1, 32'h0000_00A1, 5'd2, 32'h0000_00B2, 5'd3, 5'd4, 1'b0, 5'd0,
                  32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    vecs[1]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b1, 5'd5,
                  32'hA1, 32'hB2, 1'b0, 1'b0, 1'b1, 32'h0);
    vecs[2]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd1, 1'b1, 5'd5,
                  32'h0, 32'hA1, 1'b1, 1'b0, 1'b0, 32'h0000_0020);
    vecs[3]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b1, 5'd6,
                  32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0020);
    vecs[4]  = mk(2'b10, 5'd0, 32'h0, 5'd5, 32'h55, 5'd6, 5'd1, 1'b1, 5'd5,
                  32'h0, 32'hA1, 1'b1, 1'b0, 1'b1, 32'h0000_0060);
    vecs[5]  = mk(2'b01, 5'd6, 32'h66, 5'd0, 32'h0, 5'd5, 5'd2, 1'b0, 5'd0,
                  32'h55, 32'hB2, 1'b1, 1'b0, 1'b1, 32'h0000_0060);
    vecs[6]  = mk(2'b11, 5'd5, 32'h77, 5'd5, 32'h88, 5'd6, 5'd7, 1'b0, 5'd0,
                  32'h66, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0020);
    vecs[7]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b1, 5'd0,
                  32'h88, 32'h66, 1'b0, 1'b0, 1'b1, 32'h0);
    vecs[8]  = mk(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0,
                  32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    vecs[9]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0,
                  32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    vecs[10] = mk(2'b01, 5'd31, 32'hCAFE_F00D, 5'd0, 32'h0, 5'd30, 5'd1, 1'b1, 5'd31,
                  32'h0, 32'hA1, 1'b0, 1'b0, 1'b1, 32'h0);
    vecs[11] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd31, 5'd30, 1'b1, 5'd31,
                  32'hCAFE_F00D, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8000_0000);
    vecs[12] = mk(2'b10, 5'd0, 32'h0, 5'd31, 32'h1, 5'd30, 5'd1, 1'b0, 5'd0,
                  32'h0, 32'hA1, 1'b0, 1'b0, 1'b1, 32'h8000_0000);
    vecs[13] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd31, 5'd5, 1'b0, 5'd0,
                  32'h1, 32'h88, 1'b0, 1'b0, 1'b1, 32'h0);

    #12 rst = 1'b0;
    next_cycle();

    // Asynchronous reset between edges wipes data and scoreboard
    bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd5}; bus.wr_data = {32'h0, 32'hDEAD_BEEF};
    bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
    next_cycle();
    idle(5'd5, 5'd9);
    #2;
    check("prefill x5", bus.rd_data[31:0], 32'hDEAD_BEEF);
    check("prefill busy x9", 32'(bus.rd_busy[1]), 32'h1);
    check("prefill busy_vec", bus.busy_vec, 32'h0000_0200);
    #1;
    rst = 1'b1;
    bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd5}; bus.wr_data = {32'h0, 32'h0000_1234};
    bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
    #1;
    check("reset rd x5", bus.rd_data[31:0], 32'h0);
    check("reset rd_busy x9", 32'(bus.rd_busy[1]), 32'h0);
    check("reset busy_vec", bus.busy_vec, 32'h0);
    check("reset iss_ready", 32'(bus.iss_ready), 32'h1);
    next_cycle();
    check("reset held rd x5", bus.rd_data[31:0], 32'h0);
    check("reset held busy_vec", bus.busy_vec, 32'h0);
    rst = 1'b0;
    idle(5'd0, 5'd0);
    next_cycle();

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i]);
      #2;
      check($sformatf("v%0d rd0", i), bus.rd_data[31:0], vecs[i].e_rd0);
      check($sformatf("v%0d rd1", i), bus.rd_data[63:32], vecs[i].e_rd1);
      check($sformatf("v%0d rb0", i), 32'(bus.rd_busy[0]), 32'(vecs[i].e_rb0));
      check($sformatf("v%0d rb1", i), 32'(bus.rd_busy[1]), 32'(vecs[i].e_rb1));
      check($sformatf("v%0d iss_ready", i), 32'(bus.iss_ready), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d busy_vec", i), bus.busy_vec, vecs[i].e_bv);
      next_cycle();
    end

    // Forwarding of a pending register's writeback
    idle(5'd9, 5'd9);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
    #2;
    check("fwd issue ready", 32'(bus.iss_ready), 32'h1);
    next_cycle();
    idle(5'd9, 5'd9);
    bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd9}; bus.wr_data = {32'h0, 32'h1234_5678};
    #2;
    check("fwd same rd0", bus.rd_data[31:0], BYP ? 32'h1234_5678 : 32'h0);
    check("fwd same rd1", bus.rd_data[63:32], BYP ? 32'h1234_5678 : 32'h0);
    check("fwd same rb0", 32'(bus.rd_busy[0]), BYP ? 32'h0 : 32'h1);
    check("fwd same busy_vec", bus.busy_vec, 32'h0000_0200);
    next_cycle();
    idle(5'd9, 5'd0);
    #2;
    check("fwd next rd0", bus.rd_data[31:0], 32'h1234_5678);
    check("fwd next rb0", 32'(bus.rd_busy[0]), 32'h0);
    check("fwd next busy_vec", bus.busy_vec, 32'h0);
    next_cycle();

    // Two write ports to x7 in one cycle: port 1 wins
    idle(5'd7, 5'd0);
    bus.wr_en = 2'b11; bus.wr_addr = {5'd7, 5'd7}; bus.wr_data = {32'h2222_2222, 32'h1111_1111};
    #2;
    check("conflict same rd0", bus.rd_data[31:0], BYP ? 32'h2222_2222 : 32'h0);
    next_cycle();
    idle(5'd7, 5'd7);
    #2;
    check("conflict next rd0", bus.rd_data[31:0], 32'h2222_2222);
    check("conflict next rd1", bus.rd_data[63:32], 32'h2222_2222);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
